// File: rtl/pattern_playback_if.sv
// Playback control and LED display bundle shared by the player and its driver.
interface pattern_playback_if;
    logic        start;
    logic        abort;
    logic [31:0] pattern;
    logic [15:0] length;
    logic        busy;
    logic        done;
    logic        led_valid;
    logic        led_bit;
    logic [4:0]  bit_index;

    modport master (
        output start, abort, pattern, length,
        input  busy, done, led_valid, led_bit, bit_index
    );

    modport slave (
        input  start, abort, pattern, length,
        output busy, done, led_valid, led_bit, bit_index
    );
endinterface

// File: rtl/pattern_playback.sv
// Plays back a latched game pattern on an LED, oldest bit first,
// with a fixed on/off cadence per bit.
module pattern_playback #(
    parameter int ON_CYCLES  = 4,
    parameter int OFF_CYCLES = 2
) (
    input logic                clk,
    input logic                rst,
    pattern_playback_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ON   = 2'd1;
    localparam logic [1:0] OFF  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [7:0] ON_LOAD  = 8'(ON_CYCLES - 1);
    localparam logic [7:0] OFF_LOAD = 8'(OFF_CYCLES - 1);

    logic [1:0]  state;
    logic [31:0] pat_q;
    logic [7:0]  cnt;
    logic [4:0]  idx;
    logic [4:0]  first_idx;
    logic        empty;

    // Lengths of 32 and above all start from the top bit.
    assign first_idx = (|bus.length[15:5]) ? 5'd31 : bus.length[4:0] - 5'd1;
    assign empty     = (bus.length == 16'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pat_q <= '0;
            cnt   <= '0;
            idx   <= '0;
        end else if (bus.abort) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        pat_q <= bus.pattern;
                        if (empty) begin
                            state <= DONE;
                            idx   <= '0;
                            cnt   <= '0;
                        end else begin
                            state <= ON;
                            idx   <= first_idx;
                            cnt   <= ON_LOAD;
                        end
                    end
                end
                ON: begin
                    if (cnt == 8'd0) begin
                        state <= OFF;
                        cnt   <= OFF_LOAD;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                OFF: begin
                    if (cnt == 8'd0) begin
                        if (idx == 5'd0) begin
                            state <= DONE;
                        end else begin
                            state <= ON;
                            idx   <= idx - 5'd1;
                            cnt   <= ON_LOAD;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.led_valid = (state == ON);
    assign bus.led_bit   = (state == ON) & pat_q[idx];
    assign bus.bit_index = idx;
endmodule

// File: tb/tb_pattern_playback.sv
// Randomized and directed bench for pattern_playback against a
// timeline model of the playback schedule.
module tb_pattern_playback;
    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int P   = ON + OFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    pattern_playback_if bus();

    pattern_playback #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model: a playback is a timeline t = 1..L*P+1 cycles after the start edge.
    bit          armed = 1'b0;
    bit          m_act = 1'b0;
    int          m_t   = 0;
    int          m_len = 0;
    logic [31:0] m_pat = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0;
            armed = 1'b1;
        end else if (bus.abort) begin
            m_act = 1'b0;
        end else if (m_act) begin
            m_t++;
            if (m_t > m_len * P + 1) m_act = 1'b0;
        end else if (bus.start) begin
            m_act = 1'b1;
            m_t   = 1;
            m_len = (bus.length > 16'd32) ? 32 : int'(bus.length);
            m_pat = bus.pattern;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            logic e_done, e_valid, e_bit;
            int   e_idx;
            e_done  = m_act && (m_t == m_len * P + 1);
            e_valid = m_act && (m_t <= m_len * P) && (((m_t - 1) % P) < ON);
            e_idx   = m_len - 1 - (m_t - 1) / P;
            e_bit   = e_valid ? m_pat[e_idx] : 1'b0;
            chk("busy", 32'(bus.busy), 32'(m_act));
            chk("done", 32'(bus.done), 32'(e_done));
            chk("led_valid", 32'(bus.led_valid), 32'(e_valid));
            chk("led_bit", 32'(bus.led_bit), 32'(e_bit));
            if (e_valid) chk("bit_index", 32'(bus.bit_index), 32'(e_idx));
        end
    end

    task automatic play(input logic [31:0] p, input logic [15:0] l,
                        input int win, input bit repulse,
                        output int done_c, output int ndone,
                        output int nvalid, output int nbusy,
                        output logic [31:0] seq,
                        output int first_idx, output int last_idx);
        bit prev_v;
        done_c = 0; ndone = 0; nvalid = 0; nbusy = 0;
        seq = '0; first_idx = -1; last_idx = -1; prev_v = 1'b0;
        @(negedge clk);
        bus.pattern = p; bus.length = l; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= win; c++) begin
            if (c > 1) @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (done_c == 0) done_c = c;
            end
            if (bus.led_valid) nvalid++;
            if (bus.busy) nbusy++;
            if (bus.led_valid && !prev_v) begin
                seq = {seq[30:0], bus.led_bit};
                if (first_idx < 0) first_idx = int'(bus.bit_index);
                last_idx = int'(bus.bit_index);
            end
            prev_v = bus.led_valid;
            if (repulse && c == 3) begin
                bus.start = 1'b1; bus.pattern = ~p; bus.length = 16'd9;
            end
            if (repulse && c == 4) bus.start = 1'b0;
        end
    endtask

    initial begin
        int          dc, nd, nv, nb, fi, li;
        logic [31:0] sq;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.pattern = '0; bus.length = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_idx", 32'(bus.bit_index), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outs", {27'd0, bus.busy, bus.done, bus.led_valid,
            bus.led_bit, 1'b0}, 32'd0);

        play(32'h5, 16'd3, 25, 1'b0, dc, nd, nv, nb, sq, fi, li);
        chk("basic_done_cycle", 32'(dc), 32'd19);
        chk("basic_seq", sq, 32'h5);
        chk("basic_valid_cycles", 32'(nv), 32'd12);
        chk("basic_first_idx", 32'(fi), 32'd2);

        play(32'hffff_ffff, 16'd0, 5, 1'b0, dc, nd, nv, nb, sq, fi, li);
        chk("zero_done_cycle", 32'(dc), 32'd1);
        chk("zero_valid", 32'(nv), 32'd0);
        chk("zero_busy_cycles", 32'(nb), 32'd1);

        play(32'h8000_0001, 16'd40, 200, 1'b0, dc, nd, nv, nb, sq, fi, li);
        chk("long_done_cycle", 32'(dc), 32'd193);
        chk("long_seq", sq, 32'h8000_0001);
        chk("long_first_idx", 32'(fi), 32'd31);
        chk("long_last_idx", 32'(li), 32'd0);

        // Abort in the second ON phase (cycle 8 of a 3-bit play).
        @(negedge clk);
        bus.pattern = 32'h5; bus.length = 16'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_pre_idx", 32'(bus.bit_index), 32'd1);
        chk("abort_pre_valid", 32'(bus.led_valid), 32'd1);
        bus.abort = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; bus.start = 1'b0;
        chk("abort_outs", {29'd0, bus.busy, bus.done, bus.led_valid}, 32'd0);
        nd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        play(32'h5, 16'd3, 25, 1'b0, dc, nd, nv, nb, sq, fi, li);
        chk("after_abort_first_idx", 32'(fi), 32'd2);
        chk("after_abort_done", 32'(dc), 32'd19);

        play(32'h5, 16'd3, 30, 1'b1, dc, nd, nv, nb, sq, fi, li);
        chk("repulse_done_cycle", 32'(dc), 32'd19);
        chk("repulse_seq", sq, 32'h5);
        chk("repulse_ndone", 32'(nd), 32'd1);

        // Reset during the first OFF phase (cycle 5).
        @(negedge clk);
        bus.pattern = 32'h7; bus.length = 16'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_mid_off_busy", 32'(bus.busy), 32'd1);
        chk("rst_mid_off_valid", 32'(bus.led_valid), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_outs", {27'd0, bus.busy, bus.done, bus.led_valid,
            bus.led_bit, |bus.bit_index}, 32'd0);
        play(32'h5, 16'd3, 25, 1'b0, dc, nd, nv, nb, sq, fi, li);
        chk("after_rst_done", 32'(dc), 32'd19);
        chk("after_rst_seq", sq, 32'h5);

        for (int n = 0; n < 4000; n++) begin
            int r;
            @(negedge clk);
            r = int'($urandom_range(0, 199));
            rst = (r < 2);
            bus.abort = (r >= 2 && r < 6);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.pattern = $urandom;
            case ($urandom_range(0, 3))
                0: bus.length = 16'($urandom_range(1, 6));
                1: bus.length = 16'd0;
                2: bus.length = 16'($urandom_range(7, 40));
                default: bus.length = 16'($urandom_range(33, 65535));
            endcase
        end
        @(negedge clk);
        rst = 1'b0; bus.abort = 1'b0; bus.start = 1'b0;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
